// File: rtl/avg_pool_sequencer.sv
// Control sequencer for the 2x2 FP16 average-pooling datapath: raster pixel tracking,
// datapath strobes and pooled-output framing. Optional stall counter under POOL_STALL_CNT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start, no pixels accepted
// RUN      | accepting pixels, emitting pooled results
// WAIT_OUT | last pixel taken, waiting for final result to drain
// DONE     | one-cycle completion pulse, map index returns to 0
module avg_pool_sequencer #(
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int N_MAPS = 4,
  parameter int CW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic [2:0]    map_idx,
  output logic          dp_acc_en,
  output logic          dp_pair_sel,
  output logic          dp_shift,
  output logic          dp_row_first,
  output logic          dp_emit,
  output logic          busy,
  output logic          done
`ifdef POOL_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2 ||
      (2 ** CW) < IMG_W || (2 ** CW) < IMG_H || N_MAPS < 1 || N_MAPS > 8) begin : g_param_err
    $error("avg_pool_sequencer: illegal IMG_W/IMG_H/CW/N_MAPS combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_OUT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [2:0]    map_q, map_d;
  logic          ov_q, ov_d;
  logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d;

  logic accept, emit, col_end, row_end, map_last;

  assign col_end  = (col_q == CW'(IMG_W - 1));
  assign row_end  = (row_q == CW'(IMG_H - 1));
  assign map_last = (map_q == 3'(N_MAPS - 1));
  assign accept   = in_valid && in_ready;
  assign emit     = accept && row_q[0] && col_q[0];

  assign dp_acc_en    = accept;
  assign dp_pair_sel  = accept && col_q[0];
  assign dp_shift     = accept && col_q[0];
  assign dp_row_first = accept && !row_q[0];
  assign dp_emit      = emit;

  assign out_valid = ov_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;
  assign map_idx   = map_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        // a held result blocks new pixels so a second emit can never overwrite it
        in_ready = !(ov_q && !out_ready);
        if (in_valid && in_ready && col_end && row_end && map_last) state_d = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        busy = 1'b1;
        if (!ov_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    map_d = map_q;
    if (state_q == S_DONE) begin
      map_d = '0;
    end else if (accept) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d = '0;
          if (!map_last) map_d = map_q + 3'd1;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    ov_d   = ov_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    if (ov_q && out_ready) ov_d = 1'b0;
    if (emit) begin
      ov_d   = 1'b1;
      orow_d = row_q >> 1;
      ocol_d = col_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      map_q   <= '0;
      ov_q    <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      map_q   <= map_d;
      ov_q    <= ov_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
    end
  end

`ifdef POOL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_RUN && in_valid && !in_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_avg_pool_sequencer.sv
// Randomized self-checking bench for avg_pool_sequencer against a raster-order reference model.
module tb_avg_pool_sequencer;
  localparam int W     = 24;
  localparam int H     = 24;
  localparam int NM    = 4;
  localparam int CW    = 5;
  localparam int MAPPX = W * H;
  localparam int TOTAL = MAPPX * NM;
  localparam int NOUT  = TOTAL / 4;

  logic clk = 1'b0, rst_n, start, in_valid, in_ready, out_ready, out_valid;
  logic [CW-1:0] out_row, out_col;
  logic [2:0] map_idx;
  logic dp_acc_en, dp_pair_sel, dp_shift, dp_row_first, dp_emit, busy, done;
`ifdef POOL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  avg_pool_sequencer #(.IMG_W(W), .IMG_H(H), .N_MAPS(NM), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .map_idx(map_idx), .dp_acc_en(dp_acc_en), .dp_pair_sel(dp_pair_sel), .dp_shift(dp_shift),
    .dp_row_first(dp_row_first), .dp_emit(dp_emit), .busy(busy), .done(done)
`ifdef POOL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // stimulus knobs
  int p_valid = 100, p_ready = 100, hold_cnt = 0;
  bit start_req = 0, bp_arm = 0, start_mid = 0, start_on_done = 0;

  // reference model state
  logic [2*CW-1:0] exp_q[$];
  bit frame_active, exp_ov, hold_prev;
  int acc_cnt, out_cnt, done_due, cyc = 0, done_seen = 0, stall_m;
  logic [2*CW-1:0] prev_coord;

  task automatic reset_model();
    frame_active = 0; exp_ov = 0; hold_prev = 0;
    acc_cnt = 0; out_cnt = 0; done_due = -1; stall_m = 0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    #1;
    in_valid = ($urandom_range(99) < p_valid);
    if (bp_arm && out_valid) begin
      bp_arm = 0;
      hold_cnt = 5;
    end
    if (hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else begin
      out_ready = ($urandom_range(99) < p_ready);
    end
    start = 1'b0;
    if (start_req) begin
      start = 1'b1;
      start_req = 0;
    end
    if (start_on_done && done) start = 1'b1;
    if (start_mid && busy && acc_cnt == 700) start = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit acc, hs, exp_rdy, emit;
      logic [4:0] exp_str;
      int p, r, c;
      cyc++;
      acc  = in_valid && in_ready;
      hs   = out_valid && out_ready;
      emit = 0;
      exp_rdy = frame_active && acc_cnt < TOTAL && !(exp_ov && !out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      exp_str = '0;
      if (acc) begin
        p = acc_cnt % MAPPX;
        r = p / W;
        c = p % W;
        emit = (r % 2 == 1) && (c % 2 == 1);
        exp_str = {1'b1, c % 2 == 1, c % 2 == 1, r % 2 == 0, emit};
        chk("map_idx", 32'(map_idx), 32'(acc_cnt / MAPPX));
        acc_cnt++;
      end
      chk("strobes", 32'({dp_acc_en, dp_pair_sel, dp_shift, dp_row_first, dp_emit}), 32'(exp_str));
      if (!frame_active) chk("map_idle", 32'(map_idx), 0);
      if (hold_prev) chk("held_coord", 32'({out_row, out_col}), 32'(prev_coord));
      if (hs) begin
        chk("out_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("out_coord", 32'({out_row, out_col}), 32'(exp_q.pop_front()));
        out_cnt++;
        if (exp_q.size() == 0 && acc_cnt == TOTAL) done_due = cyc + 2;
      end
      chk("done", 32'(done), 32'(cyc == done_due));
      chk("busy", 32'(busy), 32'(frame_active && cyc != done_due));
      if (frame_active && acc_cnt < TOTAL && in_valid && !exp_rdy && !acc) stall_m++;
      hold_prev  = out_valid && !out_ready;
      prev_coord = {out_row, out_col};
      exp_ov = (acc && emit) || (exp_ov && !out_ready);
      if (done) done_seen++;
      if (start && !frame_active) begin
        frame_active = 1; acc_cnt = 0; out_cnt = 0; stall_m = 0;
        exp_q.delete();
        for (int m = 0; m < NM; m++)
          for (int rr = 0; rr < H / 2; rr++)
            for (int cc = 0; cc < W / 2; cc++)
              exp_q.push_back({CW'(rr), CW'(cc)});
      end
      if (cyc == done_due) begin
`ifdef POOL_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
        frame_active = 0;
        done_due = -1;
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_ctrl", 32'({in_ready, out_valid, busy, done, dp_acc_en, dp_pair_sel,
                         dp_shift, dp_row_first, dp_emit}), 0);
    chk("rst_coord", 32'({out_row, out_col, map_idx}), 0);
  endtask

  task automatic run_frame(input int budget);
    int d0, n;
    d0 = done_seen;
    n = 0;
    start_req = 1;
    while (done_seen == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_seen != d0), 1);
    repeat (10) @(negedge clk);
    chk("done_pulses", 32'(done_seen - d0), 1);
    chk("n_out", 32'(out_cnt), NOUT);
    chk("q_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // full-rate frame
    p_valid = 100; p_ready = 100;
    run_frame(5000);

    // backpressure burst right after the first emit
    bp_arm = 1;
    run_frame(5000);
`ifdef POOL_STALL_CNT_EN
    chk("stall_bp", 32'(stall_cnt), 5);
`endif

    // random gaps on both sides
    p_valid = 50; p_ready = 70;
    run_frame(30000);

    // reset in the middle of map 1, then a clean frame
    p_valid = 80; p_ready = 90;
    start_req = 1;
    n = 0;
    while (acc_cnt < MAPPX + 300 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_abort_point", 32'(acc_cnt >= MAPPX + 300), 1);
    rst_n = 1'b0;
    reset_model();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(20000);

    // start during RUN and on the done cycle must both be ignored
    p_valid = 100; p_ready = 100;
    start_mid = 1; start_on_done = 1;
    run_frame(5000);
    start_mid = 0; start_on_done = 0;
    n = done_seen;
    repeat (30) @(negedge clk);
    chk("no_extra_frame", 32'(done_seen - n), 0);
    chk("idle_after", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
